// File: rtl/hmc6502_pkg.sv
// hmc6502_pkg
//   Shared constants for the 6502 core: processor-status bit positions,
//   the reset value of P, the branch-condition flag-select encodings and a
//   small helper that applies the hard-wired P bits.
//
//   Optional build macro used by this block: HMC6502_DECIMAL_EN
//   (see status_reg.sv).

package hmc6502_pkg;

    // P bit positions, {N,V,U,B,D,I,Z,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    // P after reset: I=1, U=1, B=1, everything else clear
    localparam logic [7:0] P_RESET = 8'h34;

    // Bits 5 (U) and 4 (B) have no storage and always read as 1
    localparam logic [7:0] P_FIXED_ONES = 8'h30;

    // Bits that ALU results may write: N, V, Z, C
    localparam logic [7:0] ALU_WRITABLE = 8'hC3;

    // Bits that set/clear instructions and bus loads may write
    localparam logic [7:0] SC_WRITABLE = 8'hCF;

    // Branch flag select = opcode[7:6]; opcode[5] is the value to compare
    localparam logic [1:0] COND_SEL_N = 2'b00;
    localparam logic [1:0] COND_SEL_V = 2'b01;
    localparam logic [1:0] COND_SEL_C = 2'b10;
    localparam logic [1:0] COND_SEL_Z = 2'b11;

    // Full branch encodings, opcode[7:5]
    localparam logic [2:0] COND_BPL = 3'b000;
    localparam logic [2:0] COND_BMI = 3'b001;
    localparam logic [2:0] COND_BVC = 3'b010;
    localparam logic [2:0] COND_BVS = 3'b011;
    localparam logic [2:0] COND_BCC = 3'b100;
    localparam logic [2:0] COND_BCS = 3'b101;
    localparam logic [2:0] COND_BNE = 3'b110;
    localparam logic [2:0] COND_BEQ = 3'b111;

    // Apply the hard-wired U/B bits to a candidate P value
    function automatic logic [7:0] p_fix(input logic [7:0] p);
        return p | P_FIXED_ONES;
    endfunction

endpackage : hmc6502_pkg

// File: rtl/branch_cond.sv
// branch_cond
//   Pure combinational 6502 branch-condition evaluator. Selects one flag
//   with cond[2:1] and compares it against cond[0]. Kept separate so the
//   branch-prediction path can instantiate the same logic.
//
// Ports
//   flag_n  in  1  P.N
//   flag_v  in  1  P.V
//   flag_c  in  1  P.C
//   flag_z  in  1  P.Z
//   cond    in  3  opcode[7:5]
//   taken   out 1  1 when the branch condition holds

module branch_cond
    import hmc6502_pkg::*;
(
    input  logic       flag_n,
    input  logic       flag_v,
    input  logic       flag_c,
    input  logic       flag_z,
    input  logic [2:0] cond,
    output logic       taken
);

    logic sel_flag;

    always_comb begin
        sel_flag = flag_n;
        unique case (cond[2:1])
            COND_SEL_N: sel_flag = flag_n;
            COND_SEL_V: sel_flag = flag_v;
            COND_SEL_C: sel_flag = flag_c;
            COND_SEL_Z: sel_flag = flag_z;
            default:    sel_flag = flag_n;
        endcase
    end

    assign taken = (sel_flag == cond[0]);

endmodule : branch_cond

// File: rtl/status_reg.sv
// status_reg
//   6502 processor status register (P). Captures ALU flag results under a
//   per-flag write mask, handles PLP/RTI loads from the data bus and
//   SEC/CLC-style set/clear writes, feeds C and D back to the ALU, evaluates
//   the branch condition and keeps the instruction-delayed IRQ mask.
//
//   Build option: HMC6502_DECIMAL_EN
//     defined   : bcd_to_alu follows P.D
//     undefined : bcd_to_alu is tied 0; P.D is still stored so that a
//                 PLP/PHP round trip returns the pushed value.
//
// Ports
//   clk           in   1  system clock, rising edge
//   reset         in   1  synchronous, active-high
//   alu_zero      in   1  ALU Z result
//   alu_neg       in   1  ALU N result
//   alu_ovf       in   1  ALU V result
//   alu_cout      in   1  ALU carry out
//   alu_we        in   8  per-flag ALU write enable (only bits 7,6,1,0 act)
//   bus_load      in   1  load P from db_in (PLP/RTI)
//   db_in         in   8  data bus value for bus_load
//   sc_we         in   8  per-flag set/clear enable (bits 5,4 ignored)
//   sc_val        in   1  value written by sc_we
//   sync          in   1  opcode-fetch strobe
//   brk_push      in   1  B value in the pushed image
//   cond          in   3  branch select, opcode[7:5]
//   p_q           out  8  current P {N,V,1,B,D,I,Z,C}
//   p_push        out  8  image for stack push
//   c_to_alu      out  1  P.C
//   bcd_to_alu    out  1  P.D (when decimal mode is built in)
//   irq_mask      out  1  I as sampled at the last sync
//   branch_taken  out  1  branch condition for the current P

module status_reg
    import hmc6502_pkg::*;
#(
    parameter logic [7:0] RESET_P = P_RESET
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_ovf,
    input  logic       alu_cout,
    input  logic [7:0] alu_we,
    input  logic       bus_load,
    input  logic [7:0] db_in,
    input  logic [7:0] sc_we,
    input  logic       sc_val,
    input  logic       sync,
    input  logic       brk_push,
    input  logic [2:0] cond,
    output logic [7:0] p_q,
    output logic [7:0] p_push,
    output logic       c_to_alu,
    output logic       bcd_to_alu,
    output logic       irq_mask,
    output logic       branch_taken
);

    logic [7:0] p_reg;
    logic [7:0] p_next;
    logic       irq_mask_reg;

    logic [7:0] alu_vec;
    logic [7:0] alu_mask;
    logic [7:0] sc_mask;

    // Enable bits with no effect are folded away here
    logic unused_we;
    assign unused_we = ^{alu_we[5:2], sc_we[5:4]};

    // ALU results laid out in P bit order; bits without an ALU source are 0
    always_comb begin
        alu_vec         = 8'h00;
        alu_vec[FLAG_N] = alu_neg;
        alu_vec[FLAG_V] = alu_ovf;
        alu_vec[FLAG_Z] = alu_zero;
        alu_vec[FLAG_C] = alu_cout;
    end

    assign alu_mask = alu_we & ALU_WRITABLE;
    assign sc_mask  = sc_we  & SC_WRITABLE;

    // Per bit: bus_load > set/clear > ALU > hold. Reset is applied in the
    // register itself so it overrides every write source.
    always_comb begin
        p_next = p_reg;
        if (bus_load) begin
            p_next = db_in;
        end else begin
            p_next = (sc_mask & {8{sc_val}})
                   | (~sc_mask & alu_mask & alu_vec)
                   | (~sc_mask & ~alu_mask & p_reg);
        end
        p_next = p_fix(p_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_reg <= p_fix(RESET_P);
        end else begin
            p_reg <= p_next;
        end
    end

    // Sampling the registered I (not p_next) gives the one-instruction
    // delay after CLI/SEI/PLP: a write landing on a sync cycle is only
    // seen at the following sync.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_reg <= 1'b1;
        end else if (sync) begin
            irq_mask_reg <= p_reg[FLAG_I];
        end
    end

    assign p_q      = p_reg;
    assign irq_mask = irq_mask_reg;
    assign c_to_alu = p_reg[FLAG_C];

    always_comb begin
        p_push         = p_reg;
        p_push[FLAG_U] = 1'b1;
        p_push[FLAG_B] = brk_push;
    end

`ifdef HMC6502_DECIMAL_EN
    assign bcd_to_alu = p_reg[FLAG_D];
`else
    assign bcd_to_alu = 1'b0;
`endif

    branch_cond u_branch_cond (
        .flag_n (p_reg[FLAG_N]),
        .flag_v (p_reg[FLAG_V]),
        .flag_c (p_reg[FLAG_C]),
        .flag_z (p_reg[FLAG_Z]),
        .cond   (cond),
        .taken  (branch_taken)
    );

endmodule : status_reg

// File: tb/tb_status_reg.sv
module tb_status_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alu_zero = 1'b0;
    logic       alu_neg = 1'b0;
    logic       alu_ovf = 1'b0;
    logic       alu_cout = 1'b0;
    logic [7:0] alu_we = 8'h00;
    logic       bus_load = 1'b0;
    logic [7:0] db_in = 8'h00;
    logic [7:0] sc_we = 8'h00;
    logic       sc_val = 1'b0;
    logic       sync = 1'b0;
    logic       brk_push = 1'b0;
    logic [2:0] cond = 3'b000;
    logic [7:0] p_q;
    logic [7:0] p_push;
    logic       c_to_alu;
    logic       bcd_to_alu;
    logic       irq_mask;
    logic       branch_taken;

`ifdef HMC6502_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    status_reg dut (
        .clk          (clk),
        .reset        (reset),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .alu_ovf      (alu_ovf),
        .alu_cout     (alu_cout),
        .alu_we       (alu_we),
        .bus_load     (bus_load),
        .db_in        (db_in),
        .sc_we        (sc_we),
        .sc_val       (sc_val),
        .sync         (sync),
        .brk_push     (brk_push),
        .cond         (cond),
        .p_q          (p_q),
        .p_push       (p_push),
        .c_to_alu     (c_to_alu),
        .bcd_to_alu   (bcd_to_alu),
        .irq_mask     (irq_mask),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        int         id;
        logic [7:0] p;
        logic       irq;
        logic       taken;
        logic [7:0] push;
        logic       c;
        logic       bcd;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   vec_id = 0;

    task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL v%0d %s: got %02h, expected %02h", id, name, act, req);
    endtask

    // Monitor: compares DUT outputs against queued expectations in the
    // observation cycle each entry is tagged with.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.tag < cyc) begin
                chk("stale_entry", e.id, 8'(e.tag), 8'(cyc));
            end else begin
                chk("p_q",          e.id, p_q,                  e.p);
                chk("irq_mask",     e.id, {7'd0, irq_mask},     {7'd0, e.irq});
                chk("branch_taken", e.id, {7'd0, branch_taken}, {7'd0, e.taken});
                chk("p_push",       e.id, p_push,               e.push);
                chk("c_to_alu",     e.id, {7'd0, c_to_alu},     {7'd0, e.c});
                chk("bcd_to_alu",   e.id, {7'd0, bcd_to_alu},   {7'd0, e.bcd});
            end
        end
    end

    // One vector: a write cycle, then an idle observation cycle holding
    // cond/brk_push. nvzc = {alu_neg, alu_ovf, alu_zero, alu_cout}.
    task automatic vec(input logic rst, input logic [7:0] awe, input logic [3:0] nvzc,
                       input logic bl, input logic [7:0] db, input logic [7:0] scwe,
                       input logic scv, input logic syn, input logic brk, input logic [2:0] cnd,
                       input logic [7:0] ep, input logic ei, input logic et, input logic [7:0] epush);
        exp_t e;
        @(posedge clk); #1;
        reset    = rst;
        alu_we   = awe;
        {alu_neg, alu_ovf, alu_zero, alu_cout} = nvzc;
        bus_load = bl;
        db_in    = db;
        sc_we    = scwe;
        sc_val   = scv;
        sync     = syn;
        brk_push = brk;
        cond     = cnd;
        vec_id++;
        e.tag   = cyc + 1;
        e.id    = vec_id;
        e.p     = ep;
        e.irq   = ei;
        e.taken = et;
        e.push  = epush;
        e.c     = ep[0];
        e.bcd   = DEC_EN & ep[3];
        exp_q.push_back(e);
        @(posedge clk); #1;
        reset    = 1'b0;
        alu_we   = 8'h00;
        {alu_neg, alu_ovf, alu_zero, alu_cout} = 4'h0;
        bus_load = 1'b0;
        db_in    = 8'h00;
        sc_we    = 8'h00;
        sc_val   = 1'b0;
        sync     = 1'b0;
    endtask

    initial begin
        //   rst awe    nvzc  bl db     scwe   v  syn brk cond     p      irq tk  push
        vec(1, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 0, 1, 3'b101, 8'h34, 1, 0, 8'h34); // reset, BCS
        vec(0, 8'hC3, 4'h7, 0, 8'h00, 8'h00, 0, 0, 0, 3'b101, 8'h77, 1, 1, 8'h67); // ALU N V Z C
        vec(0, 8'h00, 4'h0, 0, 8'h00, 8'h01, 0, 0, 1, 3'b100, 8'h76, 1, 1, 8'h76); // CLC, BCC
        vec(0, 8'h01, 4'h0, 0, 8'h00, 8'h01, 1, 0, 1, 3'b100, 8'h77, 1, 0, 8'h77); // SEC beats ALU C
        vec(0, 8'hFF, 4'hF, 1, 8'h00, 8'hFF, 1, 0, 0, 3'b111, 8'h30, 1, 0, 8'h20); // bus_load wins
        vec(0, 8'h00, 4'h0, 0, 8'h00, 8'h04, 1, 1, 1, 3'b000, 8'h34, 0, 1, 8'h34); // SEI on sync: old I
        vec(0, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 1, 0, 3'b001, 8'h34, 1, 0, 8'h24); // sync: I=1
        vec(0, 8'h00, 4'h0, 0, 8'h00, 8'h04, 0, 1, 1, 3'b011, 8'h30, 1, 0, 8'h30); // CLI on sync: stays 1
        vec(0, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 1, 0, 3'b010, 8'h30, 0, 1, 8'h20); // next sync: 0
        vec(0, 8'h00, 4'h0, 0, 8'h00, 8'h02, 1, 0, 1, 3'b111, 8'h32, 0, 1, 8'h32); // Z=1, BEQ
        vec(0, 8'h3C, 4'hD, 0, 8'h00, 8'h00, 0, 0, 1, 3'b110, 8'h32, 0, 0, 8'h32); // alu_we[5:2] ignored, BNE
        vec(0, 8'h00, 4'h0, 0, 8'h00, 8'h08, 1, 0, 1, 3'b111, 8'h3A, 0, 1, 8'h3A); // SED
        vec(0, 8'h00, 4'h0, 0, 8'h00, 8'h30, 0, 0, 0, 3'b110, 8'h3A, 0, 0, 8'h2A); // sc_we[5:4] ignored
        vec(0, 8'h00, 4'h0, 1, 8'hFF, 8'h00, 0, 0, 0, 3'b001, 8'hFF, 0, 1, 8'hEF); // PLP FF, BMI
        vec(0, 8'h00, 4'h0, 1, 8'hC3, 8'h00, 0, 1, 1, 3'b011, 8'hF3, 1, 1, 8'hF3); // PLP on sync: old I
        vec(1, 8'hFF, 4'h0, 1, 8'hFF, 8'h00, 0, 1, 1, 3'b101, 8'h34, 1, 0, 8'h34); // reset beats writes
        vec(0, 8'h82, 4'hA, 0, 8'h00, 8'h00, 0, 0, 0, 3'b000, 8'hB6, 1, 0, 8'hA6); // N,Z only, BPL

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_status_reg
